// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for a 5-stage pipeline. It resolves three kinds of event:
//   1. A taken branch or jump resolved in MEM.
//   2. A multi-cycle multiply that occupies EX.
//   3. A load-use hazard between ID and EX.
// From these it drives the write-enables and flushes for the PC, IF/ID, ID/EX and
// EX/MEM registers.
//
// Output handshake: every control output is combinational from the current state and
// the current inputs. Each one is valid for the cycle it is observed in, and the
// pipeline registers act on it at the next rising edge. There is no ready back-pressure.
//
// Two saturating counters record stall cycles and taken-branch events.
// DbgState and DbgCnt expose the multiply-wait FSM so that checkers can bind to it.
module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             ID_UsesRt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rt,
    input  logic             IDEX_MultStart,
    input  logic [1:0]       EXMEM_Branch,
    input  logic             EXMEM_Zero,
    input  logic             CntClr,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             MultBusy,
    output logic             MultDone,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             DbgState,
    output logic [3:0]       DbgCnt
);

    typedef enum logic {
        RUN       = 1'b0,
        MULT_WAIT = 1'b1
    } state_t;

    // Value loaded into the wait counter on multiply entry. The entry cycle is
    // itself one of the MULT_CYCLES occupancy cycles.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic taken;
    logic load_use;

    // Branch resolution in MEM, and the load-use comparison between ID and EX.
    always_comb begin
        taken = ((EXMEM_Branch == 2'b01) &&  EXMEM_Zero) ||
                ((EXMEM_Branch == 2'b10) && !EXMEM_Zero) ||
                 (EXMEM_Branch == 2'b11);
        load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                   ((IDEX_Rt == IFID_Rs) || (ID_UsesRt && (IDEX_Rt == IFID_Rt)));
    end

    // FSM next state and control outputs.
    // Priority order: reset, then taken branch, then multiply, then load-use.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        PCWrite    = 1'b1;
        PCSrc      = 1'b0;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXWrite  = 1'b1;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        MultBusy   = 1'b0;
        MultDone   = 1'b0;

        if (reset) begin
            // Freeze every pipeline register and clear the latches while reset is held.
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
            state_d    = RUN;
            cnt_d      = 4'd0;
        end else if (taken) begin
            // Redirect fetch and squash the three younger instructions.
            // This also cancels any multiply that is in flight.
            PCSrc      = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
            state_d    = RUN;
            cnt_d      = 4'd0;
        end else if (state_q == MULT_WAIT) begin
            if (cnt_q > 4'd1) begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMFlush = 1'b1;
                MultBusy   = 1'b1;
                cnt_d      = cnt_q - 4'd1;
            end else begin
                // Final occupancy cycle. The pipeline advances and EX/MEM takes the product.
                MultBusy = 1'b1;
                MultDone = 1'b1;
                state_d  = RUN;
                cnt_d    = 4'd0;
            end
        end else if (IDEX_MultStart) begin
            if (MULT_CYCLES > 1) begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXWrite  = 1'b0;
                EXMEMFlush = 1'b1;
                MultBusy   = 1'b1;
                cnt_d      = MULT_LOAD;
                state_d    = MULT_WAIT;
            end else begin
                MultDone = 1'b1;
            end
        end else if (load_use) begin
            // One-cycle bubble. The load moves to MEM and the dependent instruction
            // stays in ID.
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    // Saturating performance counters. A clear takes precedence over an increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!PCWrite && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (taken && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // State, wait counter and performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counter and debug visibility.
    always_comb begin
        StallCount = stall_cnt_q;
        FlushCount = flush_cnt_q;
        DbgState   = state_q;
        DbgCnt     = cnt_q;
    end

endmodule
